// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a byte-wide synchronous memory.
// Ports: clk, rst_n; f_* fetch port; d_* data port; mem_* byte memory; busy.
module mem_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [63:0]   f_addr,
  output logic          f_done,
  output logic          f_err,
  output logic [63:0]   f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [63:0]   d_addr,
  input  logic [63:0]   d_wdata,
  output logic          d_done,
  output logic          d_err,
  output logic [63:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          last_d_q, last_d_d;
  logic          gnt_d_q, gnt_d_d;
  logic          we_q, we_d;
  logic [AW-1:0] base_q, base_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   buf_q, buf_d;
  logic [63:0]   f_rdata_q, f_rdata_d;
  logic [63:0]   d_rdata_q, d_rdata_d;
  logic          f_err_q, f_err_d;
  logic          d_err_q, d_err_d;

  logic          pick_d;
  logic [63:0]   req_addr;
  logic [64:0]   end_addr;
  logic          oor;
  logic [2:0]    cap_idx;
  logic [63:0]   result;

  // Tie goes to the port not granted last; last_d_q=0 means fetch.
  assign pick_d   = d_req & (~f_req | ~last_d_q);
  assign req_addr = pick_d ? d_addr : f_addr;
  // 65-bit sum so addresses near 2^64 cannot wrap into range.
  assign end_addr = {1'b0, req_addr} + 65'd7;
  assign oor      = end_addr > (65'(MEM_BYTES) - 65'd1);
  assign cap_idx  = cnt_q - 3'd1;
  assign result   = we_q ? 64'd0 : {mem_rdata, buf_q[55:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d_d  = last_d_q;
    gnt_d_d   = gnt_d_q;
    we_d      = we_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    f_err_d   = f_err_q;
    d_err_d   = d_err_q;
    unique case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          gnt_d_d  = pick_d;
          last_d_d = pick_d;
          we_d     = pick_d & d_we;
          base_d   = req_addr[AW-1:0];
          wdata_d  = pick_d ? d_wdata : 64'd0;
          cnt_d    = 3'd0;
          buf_d    = 64'd0;
          if (oor) begin
            state_d = DONE;
            if (pick_d) begin
              d_err_d   = 1'b1;
              d_rdata_d = 64'd0;
            end else begin
              f_err_d   = 1'b1;
              f_rdata_d = 64'd0;
            end
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Byte issued last cycle is on mem_rdata now.
        if (cnt_q != 3'd0) begin
          buf_d[{cap_idx, 3'b000} +: 8] = mem_rdata;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d = DONE;
        if (gnt_d_q) begin
          d_err_d   = 1'b0;
          d_rdata_d = result;
        end else begin
          f_err_d   = 1'b0;
          f_rdata_d = result;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      last_d_q  <= 1'b0;
      gnt_d_q   <= 1'b0;
      we_q      <= 1'b0;
      base_q    <= '0;
      wdata_q   <= 64'd0;
      buf_q     <= 64'd0;
      f_rdata_q <= 64'd0;
      d_rdata_q <= 64'd0;
      f_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_d_q  <= last_d_d;
      gnt_d_q   <= gnt_d_d;
      we_q      <= we_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      buf_q     <= buf_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
      f_err_q   <= f_err_d;
      d_err_q   <= d_err_d;
    end
  end

  assign busy      = state_q != IDLE;
  assign f_done    = (state_q == DONE) & ~gnt_d_q;
  assign d_done    = (state_q == DONE) & gnt_d_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign f_err     = f_err_q;
  assign d_err     = d_err_q;
  assign mem_en    = state_q == ACCESS;
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? base_q + AW'(cnt_q) : '0;
  assign mem_wdata = mem_en ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide synchronous memory model.
// Drives on negedge, samples on negedge, checks latency/data/err/reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req;
  logic [63:0] f_addr;
  logic        f_done, f_err;
  logic [63:0] f_rdata;
  logic        d_req, d_we;
  logic [63:0] d_addr, d_wdata;
  logic        d_done, d_err;
  logic [63:0] d_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0] mem [0:1023];
  int en_cnt   = 0;
  int viol     = 0;
  int ddone_n  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_BYTES(1024), .AW(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr),
    .f_done(f_done), .f_err(f_err), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      en_cnt <= en_cnt + 1;
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
    if (mem_we && !mem_en) viol <= viol + 1;
    if (d_done) ddone_n <= ddone_n + 1;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input bit is_d, input bit we, input logic [63:0] addr,
                      input logic [63:0] wd, output logic [63:0] rd,
                      output logic err, output int lat);
    lat = -1;
    rd  = 'x;
    err = 1'bx;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (is_d ? d_done : f_done) begin
        lat = i;
        rd  = is_d ? d_rdata : f_rdata;
        err = is_d ? d_err : f_err;
        break;
      end
    end
    d_req = 1'b0;
    f_req = 1'b0;
    @(negedge clk);
  endtask

  logic [63:0] rd;
  logic        er;
  int          lat;
  int          e0;
  int          dl, fl;
  logic [63:0] dv, fv;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem_rdata = 8'h00;
    rst_n = 1'b0;
    f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {62'd0, f_done, d_done}, 64'd0);
    check("rst_mem", {62'd0, mem_en, mem_we}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    e0 = en_cnt;
    xfer(1, 1, 64'h10, 64'h0807060504030201, rd, er, lat);
    check("wr_lat", 64'(lat), 64'd10);
    check("wr_err", {63'd0, er}, 64'd0);
    check("wr_rdata", rd, 64'd0);
    check("wr_en_cnt", 64'(en_cnt - e0), 64'd8);
    check("wr_mem", {mem[8'h17], mem[8'h16], mem[8'h15], mem[8'h14],
                     mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]},
          64'h0807060504030201);

    xfer(1, 1, 64'h18, 64'h100F0E0D0C0B0A09, rd, er, lat);
    check("wr2_lat", 64'(lat), 64'd10);

    xfer(0, 0, 64'h10, 64'd0, rd, er, lat);
    check("frd_lat", 64'(lat), 64'd10);
    check("frd_data", rd, 64'h0807060504030201);
    check("frd_err", {63'd0, er}, 64'd0);

    xfer(1, 0, 64'h13, 64'd0, rd, er, lat);
    check("mis_data", rd, 64'h0B0A090807060504);
    check("mis_err", {63'd0, er}, 64'd0);
    check("f_hold", f_rdata, 64'h0807060504030201);

    e0 = en_cnt;
    xfer(1, 0, 64'd1017, 64'd0, rd, er, lat);
    check("oor_lat", 64'(lat), 64'd1);
    check("oor_err", {63'd0, er}, 64'd1);
    check("oor_rdata", rd, 64'd0);
    check("oor_en", 64'(en_cnt - e0), 64'd0);

    xfer(0, 0, 64'd1016, 64'd0, rd, er, lat);
    check("edge_lat", 64'(lat), 64'd10);
    check("edge_err", {63'd0, er}, 64'd0);

    xfer(0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, rd, er, lat);
    check("wrap_lat", 64'(lat), 64'd1);
    check("wrap_err", {63'd0, er}, 64'd1);
    check("d_err_hold", {63'd0, d_err}, 64'd1);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dl = -1; fl = -1; dv = 'x; fv = 'x;
    d_req = 1; d_we = 0; d_addr = 64'h10;
    f_req = 1; f_addr = 64'h18;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (d_done && dl < 0) begin dl = i; dv = d_rdata; d_req = 0; end
      if (f_done && fl < 0) begin fl = i; fv = f_rdata; f_req = 0; end
      if (dl > 0 && fl > 0) break;
    end
    d_req = 0; f_req = 0;
    @(negedge clk);
    check("tie_d_lat", 64'(dl), 64'd10);
    check("tie_f_lat", 64'(fl), 64'd21);
    check("tie_d_data", dv, 64'h0807060504030201);
    check("tie_f_data", fv, 64'h100F0E0D0C0B0A09);

    e0 = ddone_n;
    d_req = 1; d_we = 1; d_addr = 64'h20; d_wdata = 64'hA8A7A6A5A4A3A2A1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    d_req = 0;
    #1;
    check("ar_busy", {63'd0, busy}, 64'd0);
    check("ar_mem", {62'd0, mem_en, mem_we}, 64'd0);
    check("ar_addr", {46'd0, mem_addr, mem_wdata}, 64'd0);
    check("ar_rdata", d_rdata, 64'd0);
    check("ar_err", {62'd0, f_err, d_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("ar_no_done", 64'(ddone_n - e0), 64'd0);
    check("ar_bytes", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]},
          64'h00A3A2A1);

    xfer(0, 0, 64'h20, 64'd0, rd, er, lat);
    check("post_lat", 64'(lat), 64'd10);
    check("post_data", rd, 64'h0000_0000_00A3_A2A1);
    check("we_no_en", 64'(viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning the byte capacity of the attached memory.
REQ-002 SHALL have parameter AW, default 10, meaning the byte-address width of the memory port.
REQ-003 SHALL have port clk  input  1  system clock; the single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port f_req  input  1  fetch port read request, held high until f_done.
REQ-006 SHALL have port f_addr  input  64  fetch port byte address.
REQ-007 SHALL have ports f_done / f_err / f_rdata  output  1/1/64  fetch completion pulse, range error, little-endian read data.
REQ-008 SHALL have ports d_req / d_we  input  1/1  data port request held until d_done, and its write (1) or read (0) select.
REQ-009 SHALL have ports d_addr / d_wdata  input  64/64  data port byte address and write data.
REQ-010 SHALL have ports d_done / d_err / d_rdata  output  1/1/64  data port completion pulse, range error, read data.
REQ-011 SHALL have ports mem_en / mem_we / mem_addr / mem_wdata  output  1/1/AW/8  byte-wide memory command.
REQ-012 SHALL have port mem_rdata  input  8  memory read byte, valid one cycle after mem_en with mem_we=0.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE, ACCESS, WAIT, DONE.
REQ-015 In IDLE with any request high, SHALL grant one port, latch its addr/we/wdata, and enter ACCESS with byte counter cnt=0 (accept cycle T).
REQ-016 On f_req and d_req both high in IDLE, SHALL grant the port not granted last; after reset, data wins the first tie.
REQ-017 Fetch grants SHALL be reads (we=0).
REQ-018 In ACCESS, cycles T+1..T+8, SHALL drive mem_en=1, mem_we=we, mem_addr=base+cnt, mem_wdata=wdata[8*cnt+7:8*cnt], with cnt incrementing 0..7.
REQ-019 Reads SHALL capture mem_rdata into result byte cnt one cycle after issuing byte cnt (little-endian assembly); byte 7 is captured in WAIT (T+9).
REQ-020 After cnt=7, SHALL enter WAIT with mem_en=0, and then DONE; writes also pass through WAIT, giving a uniform accept-to-done latency of 10 cycles.
REQ-021 In DONE (T+10), SHALL pulse done for exactly one cycle on the granted port only, with rdata valid (write: rdata=0), and then return to IDLE.
REQ-022 The next grant SHALL occur no earlier than T+11; requests seen in ACCESS, WAIT or DONE SHALL be ignored.
REQ-023 When base+7 > MEM_BYTES-1 (64-bit compare, no wrap), SHALL issue no memory cycles, go IDLE->DONE at T+1, and assert err=1 with rdata=0 alongside done.
REQ-024 Misaligned base addresses within range SHALL be legal.
REQ-025 rdata/err SHALL hold until the next completion on the same port.
REQ-026 mem_en SHALL be 0 outside ACCESS; mem_we SHALL never be 1 when mem_en is 0.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, cnt=0, last-grant=fetch, and clear all done/err/rdata/mem_* outputs and busy to 0.
REQ-028 Reset mid-ACCESS SHALL abort with no done; bytes already written SHALL remain in memory with no rollback.
REQ-029 After rst_n rises, pending requests SHALL be arbitrated normally from IDLE.

Verification
REQ-030 Data write addr=0x10, wdata=0x0807060504030201 -> bytes 0x01..0x08 written to 0x10..0x17 in T+1..T+8; d_done at T+10 with d_err=0.
REQ-031 Fetch read addr=0x10 after REQ-030 -> f_rdata=0x0807060504030201, f_done at T+10.
REQ-032 f_req and d_req rise in the same cycle after reset, both held -> data granted first, fetch granted at T+11, f_done at T+21.
REQ-033 d_addr=1017 (MEM_BYTES=1024) -> no mem_en, d_done with d_err=1 and d_rdata=0 one cycle after accept.
REQ-034 Write to 0x20 with rst_n pulsed low during cnt=3 -> bytes 0x20..0x22 (and 0x23 if its edge occurred) written, no d_done, all outputs 0 during reset.
REQ-035 Misaligned read addr=0x13 -> bytes 0x13..0x1A assembled little-endian, d_err=0.
